// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a valid/ready operand port, a registered result stage with backpressure,
// and an iterative radix-2 Booth signed multiplier.
// Ports: clk, rst_n (async, active-low); IN_A/IN_B/OPCODE/IN_VALID -> IN_READY;
//        OUT_VALID/OUT_ALU/OUT_ALU_HI/COUT <- OUT_READY.
// Optional ALU_SEQ_PARITY_EN adds IN_PAR (even parity of {OPCODE,IN_B,IN_A}), OUT_PAR and OUT_ERR.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [2:0]       OPCODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_ALU,
  output logic [WIDTH-1:0] OUT_ALU_HI,
  output logic             COUT
`ifdef ALU_SEQ_PARITY_EN
  ,
  input  logic             IN_PAR,
  output logic             OUT_PAR,
  output logic             OUT_ERR
`endif
);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_NOT = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4, OP_SHR = 3'd5, OP_AND = 3'd6, OP_OR = 3'd7;
  localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // Accumulator carries one extra bit so subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0] acc_q, acc_d, acc_n, booth_sum, m_ext;
  logic [WIDTH-1:0] q_q, q_d, q_n, m_q, m_d;
  logic qm1_q, qm1_d;
  logic valid_q, valid_d, cout_q, cout_d;
  logic [WIDTH-1:0] alu_q, alu_d, hi_q, hi_d, res;
  logic [WIDTH:0] add_s, sub_s;
  logic res_c, accept, is_mul, par_ok, wr_op, wr_mul;
  assign IN_READY   = (state_q == IDLE) && (!valid_q || OUT_READY);
  assign accept     = IN_VALID && IN_READY;
  assign is_mul     = OPCODE == OP_MUL;
`ifdef ALU_SEQ_PARITY_EN
  assign par_ok     = (^{OPCODE, IN_B, IN_A}) == IN_PAR;
`else
  assign par_ok     = 1'b1;
`endif
  // A parity-failed multiply is reported through the single-cycle path.
  assign wr_op      = accept && (!is_mul || !par_ok);
  assign wr_mul     = (state_q == MUL_RUN) && (cnt_q == CNTW'(1));
  assign add_s      = {1'b0, IN_A} + {1'b0, IN_B};
  assign sub_s      = {1'b0, IN_A} + {1'b0, ~IN_B} + (WIDTH+1)'(1);
  assign m_ext      = {m_q[WIDTH-1], m_q};
  assign booth_sum  = (q_q[0] && !qm1_q) ? acc_q - m_ext : (!q_q[0] && qm1_q) ? acc_q + m_ext : acc_q;
  assign acc_n      = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_n        = {booth_sum[0], q_q[WIDTH-1:1]};
  assign OUT_VALID  = valid_q;
  assign OUT_ALU    = alu_q;
  assign OUT_ALU_HI = hi_q;
  assign COUT       = cout_q;
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (OPCODE)
      OP_ADD: {res_c, res} = add_s;
      OP_SUB: {res_c, res} = sub_s;
      OP_NOT: res = ~IN_A;
      OP_SHL: res = ({1'b0, IN_B} >= WLIM) ? '0 : IN_A << IN_B;
      OP_SHR: res = ({1'b0, IN_B} >= WLIM) ? '0 : IN_A >> IN_B;
      OP_AND: res = IN_A & IN_B;
      OP_OR:  res = IN_A | IN_B;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    valid_d = (valid_q && OUT_READY) ? 1'b0 : valid_q;
    alu_d   = alu_q;
    hi_d    = hi_q;
    cout_d  = cout_q;
    if (state_q == MUL_RUN) begin
      acc_d = acc_n;
      q_d   = q_n;
      qm1_d = q_q[0];
      cnt_d = cnt_q - CNTW'(1);
      if (wr_mul) begin
        state_d       = IDLE;
        valid_d       = 1'b1;
        {hi_d, alu_d} = {acc_n[WIDTH-1:0], q_n};
        cout_d        = 1'b0;
      end
    end else if (accept && is_mul && par_ok) begin
      state_d = MUL_RUN;
      cnt_d   = CNTW'(WIDTH);
      acc_d   = '0;
      q_d     = IN_A;
      qm1_d   = 1'b0;
      m_d     = IN_B;
    end else if (wr_op) begin
      valid_d = 1'b1;
      alu_d   = par_ok ? res : '0;
      hi_d    = '0;
      cout_d  = par_ok && res_c;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      valid_q <= 1'b0;
      alu_q   <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
    end
  end
`ifdef ALU_SEQ_PARITY_EN
  logic err_q, err_d, par_q, par_d;
  assign OUT_ERR = err_q;
  assign OUT_PAR = par_q;
  always_comb begin
    err_d = wr_op ? !par_ok : wr_mul ? 1'b0 : err_q;
    par_d = ^{err_d, cout_d, hi_d, alu_d};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      err_q <= err_d;
      par_q <= par_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, NOTA = 3'd3;
  localparam logic [2:0] SHL = 3'd4, SHR = 3'd5, AND = 3'd6, OR = 3'd7;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [15:0] IN_A = '0, IN_B = '0;
  logic [2:0] OPCODE = '0;
  logic IN_VALID = 1'b0, OUT_READY = 1'b1;
  logic IN_READY, OUT_VALID, COUT;
  logic [15:0] OUT_ALU, OUT_ALU_HI;
  int n_checks = 0, n_fail = 0;
`ifdef ALU_SEQ_PARITY_EN
  logic IN_PAR, OUT_PAR, OUT_ERR;
  logic par_flip = 1'b0;
  assign IN_PAR = (^{OPCODE, IN_B, IN_A}) ^ par_flip;
`endif
  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .IN_A(IN_A), .IN_B(IN_B), .OPCODE(OPCODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_ALU(OUT_ALU), .OUT_ALU_HI(OUT_ALU_HI), .COUT(COUT)
`ifdef ALU_SEQ_PARITY_EN
    , .IN_PAR(IN_PAR), .OUT_PAR(OUT_PAR), .OUT_ERR(OUT_ERR)
`endif
  );
  always #5 clk = ~clk;
  // Returns {cout, hi[15:0], lo[15:0]} from plain arithmetic.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    logic signed [31:0] p;
    case (op)
      ADD: begin s = int'(a) + int'(b); return {s > 32'hFFFF, 16'h0, a + b}; end
      SUB: return {a >= b, 16'h0, a - b};
      MUL: begin p = $signed(a) * $signed(b); return {1'b0, p}; end
      NOTA: return {17'h0, ~a};
      SHL: return {17'h0, (b >= 16) ? 16'h0 : a << b};
      SHR: return {17'h0, (b >= 16) ? 16'h0 : a >> b};
      AND: return {17'h0, a & b};
      default: return {17'h0, a | b};
    endcase
  endfunction
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [32:0] e;
    int lat, t, exp_lat;
    logic rdy_hi;
    e = model(op, a, b);
    exp_lat = (op == MUL) ? 16 : 0;
    @(negedge clk);
    OUT_READY = 1'b1; IN_A = a; IN_B = b; OPCODE = op; IN_VALID = 1'b1;
    #1;
    t = 0;
    while (!IN_READY && t < 50) begin @(negedge clk); #1; t++; end
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL accept op%0d: IN_READY=%b required 1", op, IN_READY); end
    @(posedge clk); #1 IN_VALID = 1'b0;
    lat = 0; rdy_hi = 1'b0;
    @(negedge clk);
    while (OUT_VALID !== 1'b1 && lat < 40) begin rdy_hi = rdy_hi | IN_READY; @(negedge clk); lat++; end
    n_checks++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL latency op%0d a=%h b=%h: got %0d required %0d", op, a, b, lat, exp_lat); end
    n_checks++;
    if (OUT_ALU !== e[15:0]) begin n_fail++; $display("FAIL lo op%0d a=%h b=%h: got %h required %h", op, a, b, OUT_ALU, e[15:0]); end
    n_checks++;
    if (OUT_ALU_HI !== e[31:16]) begin n_fail++; $display("FAIL hi op%0d a=%h b=%h: got %h required %h", op, a, b, OUT_ALU_HI, e[31:16]); end
    n_checks++;
    if (COUT !== e[32]) begin n_fail++; $display("FAIL cout op%0d a=%h b=%h: got %b required %b", op, a, b, COUT, e[32]); end
    if (op == MUL) begin
      n_checks++;
      if (rdy_hi !== 1'b0) begin n_fail++; $display("FAIL mul_ready_low: IN_READY seen %b required 0", rdy_hi); end
    end
`ifdef ALU_SEQ_PARITY_EN
    n_checks++;
    if (OUT_ERR !== 1'b0 || OUT_PAR !== ^e) begin n_fail++; $display("FAIL par op%0d: err=%b par=%b required 0 %b", op, OUT_ERR, OUT_PAR, ^e); end
`endif
  endtask
  task automatic test_reset();
    n_checks++;
    if ({OUT_VALID, OUT_ALU, OUT_ALU_HI, COUT} !== 34'h0 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset: valid=%b alu=%h hi=%h cout=%b rdy=%b required 0 0 0 0 1", OUT_VALID, OUT_ALU, OUT_ALU_HI, COUT, IN_READY);
    end
  endtask
  task automatic test_directed();
    do_op(ADD, 16'hFFFF, 16'h0001);
    do_op(SUB, 16'h0005, 16'h0007);
    do_op(SUB, 16'h0007, 16'h0005);
    do_op(MUL, 16'hFFFD, 16'h0007);
    do_op(MUL, 16'h8000, 16'h8000);
    do_op(MUL, 16'h7FFF, 16'h8000);
    do_op(SHL, 16'h0001, 16'd20);
    do_op(SHL, 16'h0001, 16'd16);
    do_op(SHR, 16'h8000, 16'd15);
    do_op(NOTA, 16'h0F0F, 16'h1234);
  endtask
  task automatic test_back_to_back();
    logic [15:0] exp_q[10];
    logic [32:0] m;
    @(negedge clk); IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_ALU !== exp_q[i-1]) begin
          n_fail++; $display("FAIL b2b[%0d]: valid=%b alu=%h required 1 %h", i-1, OUT_VALID, OUT_ALU, exp_q[i-1]);
        end
      end
      if (i < 10) begin
        IN_A = 16'($urandom); IN_B = 16'($urandom); OPCODE = (i % 2 == 1) ? OR : AND; IN_VALID = 1'b1;
        m = model(OPCODE, IN_A, IN_B);
        exp_q[i] = m[15:0];
        #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, IN_READY); end
      end else IN_VALID = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_backpressure();
    logic [32:0] e1, e2;
    @(negedge clk); IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge clk);
    OUT_READY = 1'b0; IN_A = 16'h1234; IN_B = 16'h0F0F; OPCODE = AND; IN_VALID = 1'b1;
    e1 = model(AND, 16'h1234, 16'h0F0F);
    e2 = model(ADD, 16'h1111, 16'h2222);
    @(posedge clk);
    @(negedge clk);
    IN_A = 16'h1111; IN_B = 16'h2222; OPCODE = ADD;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_ALU !== e1[15:0] || OUT_ALU_HI !== 16'h0 || IN_READY !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: valid=%b alu=%h hi=%h rdy=%b required 1 %h 0 0", i, OUT_VALID, OUT_ALU, OUT_ALU_HI, IN_READY, e1[15:0]);
      end
      @(negedge clk);
    end
    OUT_READY = 1'b1;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b required 1", IN_READY); end
    @(posedge clk); #1 IN_VALID = 1'b0;
    @(negedge clk);
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_ALU !== e2[15:0]) begin
      n_fail++; $display("FAIL release_result: valid=%b alu=%h required 1 %h", OUT_VALID, OUT_ALU, e2[15:0]);
    end
  endtask
  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      do_op(op, 16'($urandom), (op == SHL || op == SHR) ? 16'($urandom_range(0, 20)) : 16'($urandom));
    end
  endtask
  task automatic test_reset_mid_mul();
    logic seen;
    do_op(ADD, 16'h1111, 16'h2222);
    @(negedge clk);
    OUT_READY = 1'b1; IN_A = 16'h1234; IN_B = 16'h5678; OPCODE = MUL; IN_VALID = 1'b1;
    @(posedge clk); #1 IN_VALID = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({OUT_VALID, OUT_ALU, OUT_ALU_HI, COUT} !== 34'h0) begin
      n_fail++; $display("FAIL mid_mul_reset: valid=%b alu=%h hi=%h cout=%b required all 0", OUT_VALID, OUT_ALU, OUT_ALU_HI, COUT);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin @(negedge clk); seen = seen | OUT_VALID; end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL discarded_mul: OUT_VALID seen %b required 0", seen); end
    do_op(ADD, 16'd3, 16'd4);
  endtask
`ifdef ALU_SEQ_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    OUT_READY = 1'b1; IN_A = 16'hFFFD; IN_B = 16'h0007; OPCODE = MUL; par_flip = 1'b1; IN_VALID = 1'b1;
    @(posedge clk); #1 IN_VALID = 1'b0; par_flip = 1'b0;
    @(negedge clk);
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_ERR !== 1'b1 || {OUT_ALU_HI, OUT_ALU, COUT} !== 33'h0 || OUT_PAR !== 1'b1) begin
      n_fail++; $display("FAIL parity_err: valid=%b err=%b hi=%h lo=%h cout=%b par=%b required 1 1 0 0 0 1", OUT_VALID, OUT_ERR, OUT_ALU_HI, OUT_ALU, COUT, OUT_PAR);
    end
    do_op(MUL, 16'hFFFD, 16'h0007);
    do_op(ADD, 16'hFFFF, 16'h0001);
  endtask
`endif
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
`ifdef ALU_SEQ_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
